// File: rtl/sound_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sound_bus_ctrl
//   Sound-subsystem bus controller for NUM_POKEY POKEY instances. It decodes
//   the POKEY chip selects, registers the POKEY read-back data and holds the
//   8-bit audio output latch. It also runs a debounced amplifier-shutdown FSM
//   with power-on pop suppression and a registered summing mixer.
//
// Ports
//   clk            system clock (only clock)
//   rst            synchronous active-low reset
//   clk_3MHz_en    3 MHz enable: qualifies latch writes and mixer updates
//   clk_6KHz_en    6 kHz enable: debounce tick for the shutdown FSM
//   mod_redbaron   selects the alternate POKEY base window
//   should_read    CPU write strobe (1 = write cycle)
//   addr_to_bram   CPU address
//   data_to_bram   CPU write data
//   pokey_dout     packed POKEY read data, POKEY i at [8i+7:8i]
//   pokey_audio    packed POKEY audio, POKEY i at [AUD_W*i +: AUD_W]
//   pokey_cs_n     active-low chip selects (combinational)
//   data_from_bram registered POKEY read data
//   latch_out      output latch contents
//   audiosel       latch_out[0]
//   amp_sd         debounced amplifier shutdown (1 = muted)
//   audio_mix      registered sum of all POKEY audio channels
// -----------------------------------------------------------------------------
module sound_bus_ctrl #(
    parameter int          NUM_POKEY      = 2,
    parameter int          AUD_W          = 4,
    parameter logic [15:0] POKEY_BASE     = 16'h1820,
    parameter logic [15:0] POKEY_BASE_ALT = 16'h1810,
    parameter logic [15:0] POKEY_STRIDE   = 16'h0010,
    parameter logic [15:0] LATCH_ADDR     = 16'h1840,
    parameter logic [15:0] LATCH_ADDR_ALT = 16'h1808,
    parameter int          MUTE_TICKS     = 8,
    localparam int         MIX_W          = AUD_W + ((NUM_POKEY > 1) ? $clog2(NUM_POKEY) : 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_3MHz_en,
    input  logic                       clk_6KHz_en,
    input  logic                       mod_redbaron,
    input  logic                       should_read,
    input  logic [15:0]                addr_to_bram,
    input  logic [7:0]                 data_to_bram,
    input  logic [8*NUM_POKEY-1:0]     pokey_dout,
    input  logic [AUD_W*NUM_POKEY-1:0] pokey_audio,
    output logic [NUM_POKEY-1:0]       pokey_cs_n,
    output logic [7:0]                 data_from_bram,
    output logic [7:0]                 latch_out,
    output logic                       audiosel,
    output logic                       amp_sd,
    output logic [MIX_W-1:0]           audio_mix
);

    localparam int CNT_W = (MUTE_TICKS > 1) ? $clog2(MUTE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUTE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE      = 2'd0,
        ST_PEND_MUTE   = 2'd1,
        ST_MUTED       = 2'd2,
        ST_PEND_UNMUTE = 2'd3
    } amp_state_e;

    logic [NUM_POKEY-1:0] in_win_s;
    logic                 win_hit_s;
    logic [7:0]           rd_data_s;
    logic [MIX_W-1:0]     mix_sum_s;
    logic                 latch_we_s;
    logic                 req_s;

    logic [7:0]       data_q,  data_d;
    logic [7:0]       latch_q, latch_d;
    logic [MIX_W-1:0] mix_q,   mix_d;
    logic             amp_sd_q, amp_sd_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    amp_state_e       state_q, state_d;

    // Window decode; 17-bit math so a window ending at 0xFFFF cannot wrap
    always_comb begin
        logic [16:0] base_s;
        logic [16:0] lo_s;
        in_win_s  = '0;
        win_hit_s = 1'b0;
        rd_data_s = 8'h00;
        if (mod_redbaron) begin
            base_s = {1'b0, POKEY_BASE_ALT};
        end else begin
            base_s = {1'b0, POKEY_BASE};
        end
        for (int i = 0; i < NUM_POKEY; i++) begin
            lo_s = base_s + ({1'b0, POKEY_STRIDE} * 17'(i));
            if (({1'b0, addr_to_bram} >= lo_s) &&
                ({1'b0, addr_to_bram} < (lo_s + {1'b0, POKEY_STRIDE}))) begin
                in_win_s[i] = 1'b1;
                win_hit_s   = 1'b1;
                rd_data_s   = pokey_dout[8*i +: 8];
            end else begin
                in_win_s[i] = 1'b0;
            end
        end
    end

    // Chip selects are forced inactive while reset is held
    always_comb begin
        if (!rst) begin
            pokey_cs_n = '1;
        end else begin
            pokey_cs_n = ~in_win_s;
        end
    end

    // Unsigned sum of all audio channels; MIX_W is wide enough for no overflow
    always_comb begin
        mix_sum_s = '0;
        for (int i = 0; i < NUM_POKEY; i++) begin
            mix_sum_s = mix_sum_s + MIX_W'(pokey_audio[AUD_W*i +: AUD_W]);
        end
    end

    // Read-back capture, latch write and mixer next-state
    always_comb begin
        latch_we_s = should_read && clk_3MHz_en &&
                     ((addr_to_bram == LATCH_ADDR) || (addr_to_bram == LATCH_ADDR_ALT));
        if (!should_read && win_hit_s) begin
            data_d = rd_data_s;
        end else begin
            data_d = data_q;
        end
        if (latch_we_s) begin
            latch_d = data_to_bram;
        end else begin
            latch_d = latch_q;
        end
        if (clk_3MHz_en) begin
            mix_d = amp_sd_q ? '0 : mix_sum_s;
        end else begin
            mix_d = mix_q;
        end
    end

    // Registered latch bit 5 is the request, so a same-cycle write is seen next cycle
    assign req_s = latch_q[5];

    // Shutdown FSM next-state: a request change must survive MUTE_TICKS ticks
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        amp_sd_d = amp_sd_q;
        case (state_q)
            ST_ACTIVE: begin
                amp_sd_d = 1'b0;
                if (req_s) begin
                    state_d = ST_PEND_MUTE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_PEND_MUTE: begin
                if (!req_s) begin
                    state_d = ST_ACTIVE;
                end else if (clk_6KHz_en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_MUTED;
                        amp_sd_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_MUTED: begin
                amp_sd_d = 1'b1;
                if (!req_s) begin
                    state_d = ST_PEND_UNMUTE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_MUTED;
                end
            end
            ST_PEND_UNMUTE: begin
                if (req_s) begin
                    state_d = ST_MUTED;
                end else if (clk_6KHz_en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_ACTIVE;
                        amp_sd_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = ST_MUTED;
                amp_sd_d = 1'b1;
                cnt_d    = '0;
            end
        endcase
    end

    // State register; reset starts muted for power-on pop suppression
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= 8'h00;
            latch_q  <= 8'h00;
            mix_q    <= '0;
            amp_sd_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_MUTED;
        end else begin
            data_q   <= data_d;
            latch_q  <= latch_d;
            mix_q    <= mix_d;
            amp_sd_q <= amp_sd_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign data_from_bram = data_q;
    assign latch_out      = latch_q;
    assign audiosel       = latch_q[0];
    assign amp_sd         = amp_sd_q;
    assign audio_mix      = mix_q;

endmodule

// File: tb/tb_sound_bus_ctrl.sv
module tb_sound_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_3MHz_en;
    logic        clk_6KHz_en;
    logic        mod_redbaron;
    logic        should_read;
    logic [15:0] addr_to_bram;
    logic [7:0]  data_to_bram;
    logic [15:0] pokey_dout;
    logic [7:0]  pokey_audio;
    logic [1:0]  pokey_cs_n;
    logic [7:0]  data_from_bram;
    logic [7:0]  latch_out;
    logic        audiosel;
    logic        amp_sd;
    logic [4:0]  audio_mix;

    int total = 0;
    int bad   = 0;

    sound_bus_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .clk_3MHz_en    (clk_3MHz_en),
        .clk_6KHz_en    (clk_6KHz_en),
        .mod_redbaron   (mod_redbaron),
        .should_read    (should_read),
        .addr_to_bram   (addr_to_bram),
        .data_to_bram   (data_to_bram),
        .pokey_dout     (pokey_dout),
        .pokey_audio    (pokey_audio),
        .pokey_cs_n     (pokey_cs_n),
        .data_from_bram (data_from_bram),
        .latch_out      (latch_out),
        .audiosel       (audiosel),
        .amp_sd         (amp_sd),
        .audio_mix      (audio_mix)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        rb;
        logic [1:0]  cs;
    } dec_vec_t;

    dec_vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        clk_6KHz_en = 1'b1;
        step();
        clk_6KHz_en = 1'b0;
        step();
    endtask

    // One write cycle, then one idle cycle so the FSM has seen the new request
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic en3);
        should_read  = 1'b1;
        addr_to_bram = a;
        data_to_bram = d;
        clk_3MHz_en  = en3;
        step();
        should_read  = 1'b0;
        clk_3MHz_en  = 1'b0;
        addr_to_bram = 16'h0000;
        step();
    endtask

    task automatic en3_pulse();
        clk_3MHz_en = 1'b1;
        step();
        clk_3MHz_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1820, 1'b0, 2'b10};
        vecs[1] = '{16'h182F, 1'b0, 2'b10};
        vecs[2] = '{16'h1830, 1'b0, 2'b01};
        vecs[3] = '{16'h1840, 1'b0, 2'b11};
        vecs[4] = '{16'h1815, 1'b1, 2'b10};
        vecs[5] = '{16'h181F, 1'b0, 2'b11};
        vecs[6] = '{16'h183F, 1'b0, 2'b01};
        vecs[7] = '{16'h1820, 1'b1, 2'b01};
        vecs[8] = '{16'h1830, 1'b1, 2'b11};
        vecs[9] = '{16'h0000, 1'b0, 2'b11};

        rst          = 1'b0;
        clk_3MHz_en  = 1'b0;
        clk_6KHz_en  = 1'b0;
        mod_redbaron = 1'b0;
        should_read  = 1'b0;
        addr_to_bram = 16'h1820;
        data_to_bram = 8'h00;
        pokey_dout   = 16'hA53C;
        pokey_audio  = 8'h00;
        step();
        step();
        chk("rst_cs_n", 32'(pokey_cs_n), 32'h3);
        chk("rst_data", 32'(data_from_bram), 32'h00);
        chk("rst_latch", 32'(latch_out), 32'h00);
        chk("rst_audiosel", 32'(audiosel), 32'h0);
        chk("rst_amp_sd", 32'(amp_sd), 32'h1);
        chk("rst_mix", 32'(audio_mix), 32'h00);

        // Power-on: amp_sd must drop on exactly the 8th tick
        rst          = 1'b1;
        addr_to_bram = 16'h0000;
        step();
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("poweron_tick%0d", k), 32'(amp_sd), (k < 8) ? 32'h1 : 32'h0);
        end

        // Decode table
        for (int i = 0; i < 10; i++) begin
            addr_to_bram = vecs[i].addr;
            mod_redbaron = vecs[i].rb;
            #1;
            chk($sformatf("decode_%0d", i), 32'(pokey_cs_n), 32'(vecs[i].cs));
        end
        mod_redbaron = 1'b0;

        // Read-back
        should_read  = 1'b0;
        addr_to_bram = 16'h1832;
        step();
        chk("rd_win1", 32'(data_from_bram), 32'hA5);
        addr_to_bram = 16'h2000;
        step();
        chk("rd_hold", 32'(data_from_bram), 32'hA5);
        addr_to_bram = 16'h1825;
        step();
        chk("rd_win0", 32'(data_from_bram), 32'h3C);
        should_read  = 1'b1;
        addr_to_bram = 16'h1832;
        step();
        chk("rd_write_cycle_hold", 32'(data_from_bram), 32'h3C);
        should_read  = 1'b0;
        addr_to_bram = 16'h0000;

        // Latch writes
        wr(16'h1808, 8'h21, 1'b1);
        chk("latch_alt", 32'(latch_out), 32'h21);
        chk("audiosel", 32'(audiosel), 32'h1);
        wr(16'h1840, 8'h00, 1'b0);
        chk("latch_no_en", 32'(latch_out), 32'h21);
        wr(16'h1840, 8'h01, 1'b1);
        chk("latch_pri", 32'(latch_out), 32'h01);
        chk("amp_after_short_req", 32'(amp_sd), 32'h0);

        // Glitch on bit5 shorter than the debounce
        wr(16'h1840, 8'h20, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("glitch_on_%0d", k), 32'(amp_sd), 32'h0);
        end
        wr(16'h1840, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("glitch_off_%0d", k), 32'(amp_sd), 32'h0);
        end

        // Mixer
        pokey_audio = {4'h9, 4'hF};
        step();
        chk("mix_hold_no_en", 32'(audio_mix), 32'h00);
        en3_pulse();
        chk("mix_sum", 32'(audio_mix), 32'h18);
        pokey_audio = 8'h00;
        step();
        chk("mix_hold", 32'(audio_mix), 32'h18);
        pokey_audio = {4'h9, 4'hF};

        // Sustained mute request
        wr(16'h1840, 8'h20, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("mute_tick%0d", k), 32'(amp_sd), (k < 8) ? 32'h0 : 32'h1);
        end
        en3_pulse();
        chk("mix_muted", 32'(audio_mix), 32'h00);

        // Unmute, then reset in the middle of PEND_MUTE
        wr(16'h1840, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        chk("unmuted", 32'(amp_sd), 32'h0);
        en3_pulse();
        chk("mix_again", 32'(audio_mix), 32'h18);
        wr(16'h1840, 8'h20, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        chk("pend_amp", 32'(amp_sd), 32'h0);
        rst          = 1'b0;
        should_read  = 1'b0;
        addr_to_bram = 16'h1832;
        clk_3MHz_en  = 1'b1;
        #1;
        chk("midrst_cs_n", 32'(pokey_cs_n), 32'h3);
        step();
        chk("midrst_data", 32'(data_from_bram), 32'h00);
        chk("midrst_latch", 32'(latch_out), 32'h00);
        chk("midrst_audiosel", 32'(audiosel), 32'h0);
        chk("midrst_amp_sd", 32'(amp_sd), 32'h1);
        chk("midrst_mix", 32'(audio_mix), 32'h00);
        clk_3MHz_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sound_bus_ctrl.md
Name: sound_bus_ctrl

Overview:
Parametrised sound-subsystem bus controller that replaces the fixed single-POKEY glue logic. It handles:
- chip-select decode for NUM_POKEY POKEY instances, with a selectable base window for alternate board variants;
- registered read-back mux from those instances;
- the 8-bit audio output latch;
- a debounced amplifier-shutdown state machine with power-on pop suppression;
- a registered summing mixer of all POKEY audio channels.

It sits between the CPU bus decode and the POKEY instances and audio output.

Parameters:
NUM_POKEY, 2, number of POKEY instances decoded and mixed (1..4)
AUD_W, 4, width of each POKEY audio output
POKEY_BASE, 16'h1820, base address of POKEY window 0 when mod_redbaron=0
POKEY_BASE_ALT, 16'h1810, base address of POKEY window 0 when mod_redbaron=1
POKEY_STRIDE, 16'h0010, window size and spacing per POKEY
LATCH_ADDR, 16'h1840, primary output-latch address
LATCH_ADDR_ALT, 16'h1808, alternate output-latch address
MUTE_TICKS, 8, number of clk_6KHz_en ticks a shutdown-request change must stay stable before amp_sd follows

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-low reset
clk_3MHz_en  in  1  3 MHz enable pulse
clk_6KHz_en  in  1  6 kHz enable pulse
mod_redbaron  in  1  selects POKEY_BASE_ALT
should_read  in  1  CPU write strobe (1 = write cycle)
addr_to_bram  in  16  CPU address
data_to_bram  in  8  CPU write data
pokey_dout  in  8*NUM_POKEY  read data from POKEY i, packed at bits [8i+7:8i]
pokey_audio  in  AUD_W*NUM_POKEY  audio from POKEY i, packed
pokey_cs_n  out  NUM_POKEY  active-low chip select per POKEY
data_from_bram  out  8  registered POKEY read data
latch_out  out  8  output latch contents
audiosel  out  1  latch_out[0]
amp_sd  out  1  debounced amplifier shutdown (1 = muted)
audio_mix  out  AUD_W+clog2(NUM_POKEY)  mixed audio (clog2 term is at least 1)

Behaviour:
- Reset: applies only while rst=0 at a clk edge. It overrides all other activity, including mid-debounce and mid-write.
  - Reset values: data_from_bram=0, latch_out=0, audiosel=0, audio_mix=0, amp_sd=1, FSM=MUTED, counter=0.
- Chip-select decode (combinational, zero latency):
  - base = mod_redbaron ? POKEY_BASE_ALT : POKEY_BASE.
  - pokey_cs_n[i] = 0 iff base + i*STRIDE <= addr < base + (i+1)*STRIDE.
  - At most one select is low. Every select is high outside all windows and during reset.
- Read-back: data_from_bram updates one cycle after the address.
  - Each clk with should_read=0 and addr in window i: data_from_bram <= pokey_dout[i].
  - Otherwise data_from_bram holds its value.
- Output latch:
  - Written with data_to_bram when should_read=1 AND clk_3MHz_en=1 AND addr equals LATCH_ADDR or LATCH_ADDR_ALT.
  - A write without clk_3MHz_en is ignored. Visible on latch_out the next cycle.
- Shutdown FSM: req = latch_out[5] (registered value, so a latch write and a tick in the same cycle uses the old req).
  - ACTIVE (amp_sd=0): if req=1 → PEND_MUTE, counter=0.
  - PEND_MUTE (amp_sd=0):
    - req=0 → ACTIVE.
    - Else each clk_6KHz_en increments the counter; on the tick where counter reaches MUTE_TICKS-1 → MUTED.
  - MUTED (amp_sd=1): if req=0 → PEND_UNMUTE, counter=0.
  - PEND_UNMUTE (amp_sd=1):
    - req=1 → MUTED.
    - Else ticks as above; at completion → ACTIVE.
  - amp_sd changes on the same edge as the state transition.
  - After reset with latch bit 5 = 0: amp_sd deasserts exactly MUTE_TICKS ticks later (power-on pop suppression).
- Mixer, updated only on clk_3MHz_en:
  - audio_mix <= amp_sd ? 0 : unsigned sum of all pokey_audio channels.
  - Output width guarantees no overflow; no saturation needed.
  - Holds between enables.

Test Plan:
1. Decode sweep, NUM_POKEY=2, mod_redbaron=0:
   - addr 0x1820 → cs_n=2'b10; 0x182F → 2'b10; 0x1830 → 2'b01; 0x1840 → 2'b11.
   - With mod_redbaron=1: addr 0x1815 → 2'b10.
2. Read-back: should_read=0, addr 0x1832, pokey_dout[15:8]=0xA5 → data_from_bram=0xA5 one cycle later. Then addr 0x2000 → value holds 0xA5.
3. Latch writes:
   - Write 0x21 to 0x1808 with clk_3MHz_en=1 → latch_out=0x21, audiosel=1.
   - Write 0x00 to 0x1840 with clk_3MHz_en=0 → latch_out stays 0x21.
4. Power-on mute, MUTE_TICKS=8:
   - Release reset → amp_sd=1, deasserts on the 8th clk_6KHz_en.
   - Write bit5=1, then bit5=0 after 3 ticks → amp_sd stays 0 throughout.
5. Mixer: channels 4'hF and 4'h9, amp_sd=0 → audio_mix=5'h18 on the next clk_3MHz_en. Hold bit5=1 for 8 ticks → audio_mix=0.
6. Reset mid-PEND_MUTE (counter=5) → all outputs return to reset values on the next edge; cs_n=all ones during reset.
